// File: rtl/wall_map_server_pkg.sv
// -----------------------------------------------------------------------------
// wall_map_server_pkg
// Shared game-field definitions for the wall map server:
//   MAP_W / MAP_H     field size in cells (columns / rows)
//   FIFO_DEPTH        depth of the cell-write FIFO (power of two)
//   COORD_W           width of a column/row coordinate
//   LAST_ROW          index of the bottom field row
//   map_state_e       INIT / IDLE / DRAIN controller states
//   wr_entry_t        one queued cell write {x, y, data}
//   default_row(y)    wall bits of row y in the new-game map
// -----------------------------------------------------------------------------
package wall_map_server_pkg;

   localparam int MAP_W      = 64;
   localparam int MAP_H      = 44;
   localparam int FIFO_DEPTH = 4;
   localparam int COORD_W    = 6;

   localparam logic [COORD_W-1:0] LAST_ROW = COORD_W'(MAP_H - 1);

   typedef enum logic [1:0] {
      ST_INIT,
      ST_IDLE,
      ST_DRAIN
   } map_state_e;

   typedef struct packed {
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
      logic               data;
   } wr_entry_t;

   // Border cells are walls, plus one pillar in every 8x8 tile at (4,4).
   function automatic logic [MAP_W-1:0] default_row(input logic [COORD_W-1:0] y);
      logic [MAP_W-1:0] row;
      row = '0;
      for (int x = 0; x < MAP_W; x++) begin
         row[x] = (x == 0) || (x == MAP_W - 1) ||
                  (y == '0) || (y == LAST_ROW) ||
                  (((x % 8) == 4) && (y[2:0] == 3'd4));
      end
      return row;
   endfunction

endpackage

// File: rtl/wall_map_server_if.sv
// -----------------------------------------------------------------------------
// wall_map_server_if
// Bundles the wall map server's request/response signals.
//   Display query : i_request_x, i_request_y, i_buzy      -> o_is_wall
//   Game query    : i_game_x, i_game_y                    -> o_game_is_wall
//   Cell write    : i_wr_valid, i_wr_x, i_wr_y, i_wr_data -> o_wr_ready
//   Control       : i_clear                               -> o_init_done
// Modports: master = client side (display + game logic), slave = map server.
// -----------------------------------------------------------------------------
interface wall_map_server_if;
   import wall_map_server_pkg::*;

   logic [COORD_W-1:0] i_request_x;
   logic [COORD_W-1:0] i_request_y;
   logic               i_buzy;
   logic               o_is_wall;

   logic [COORD_W-1:0] i_game_x;
   logic [COORD_W-1:0] i_game_y;
   logic               o_game_is_wall;

   logic               i_wr_valid;
   logic [COORD_W-1:0] i_wr_x;
   logic [COORD_W-1:0] i_wr_y;
   logic               i_wr_data;
   logic               o_wr_ready;

   logic               i_clear;
   logic               o_init_done;

   modport master (
      output i_request_x, i_request_y, i_buzy,
      output i_game_x, i_game_y,
      output i_wr_valid, i_wr_x, i_wr_y, i_wr_data,
      output i_clear,
      input  o_is_wall, o_game_is_wall, o_wr_ready, o_init_done
   );

   modport slave (
      input  i_request_x, i_request_y, i_buzy,
      input  i_game_x, i_game_y,
      input  i_wr_valid, i_wr_x, i_wr_y, i_wr_data,
      input  i_clear,
      output o_is_wall, o_game_is_wall, o_wr_ready, o_init_done
   );

endinterface

// File: rtl/wall_map_server_wr_fifo.sv
// -----------------------------------------------------------------------------
// wall_wr_fifo
// Show-ahead FIFO holding pending cell writes for the wall map.
//   clk, rst_n  clock, synchronous active-low reset (empties the FIFO)
//   i_flush     drop all entries this cycle (overrides push/pop)
//   i_push      write i_data (ignored when full)
//   i_pop       discard head entry (ignored when empty)
//   o_data      current head entry, valid while !o_empty
//   o_full, o_empty, o_count  occupancy status
// -----------------------------------------------------------------------------
module wall_wr_fifo
   import wall_map_server_pkg::*;
#(
   parameter int DEPTH = FIFO_DEPTH
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       i_flush,
   input  logic                       i_push,
   input  wr_entry_t                  i_data,
   input  logic                       i_pop,
   output wr_entry_t                  o_data,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH+1)-1:0] o_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   wr_entry_t         mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              do_push;
   logic              do_pop;

   assign o_full  = (count_q == CNT_W'(DEPTH));
   assign o_empty = (count_q == '0);
   assign o_count = count_q;
   assign o_data  = mem_q[rd_ptr_q];

   always_comb begin
      do_push  = i_push && !o_full;
      do_pop   = i_pop && !o_empty;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;   // DEPTH is a power of two: natural wrap
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      if (i_flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Payload storage needs no reset; occupancy is tracked by the pointers.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= i_data;
      end
   end

endmodule

// File: rtl/wall_map_server.sv
// -----------------------------------------------------------------------------
// wall_map_server
// Owner of the 64x44 one-bit wall map. Serves display and collision queries
// with a registered 1-cycle read, applies queued cell writes from game logic,
// and rebuilds the default map (one row per cycle) after reset or i_clear.
// Ports:
//   clk    system (pixel) clock
//   rst_n  synchronous active-low reset
//   bus    wall_map_server_if.slave: display query, game query, cell write
//          channel, clear pulse and init-done status
// Build option:
//   WALL_MAP_FRAME_SYNC_EN  when defined, queued writes are applied only while
//                           i_buzy is low, so the map is frozen during the
//                           active display region.
// -----------------------------------------------------------------------------
module wall_map_server
   import wall_map_server_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   wall_map_server_if.slave bus
);

   map_state_e         state_q, state_d;
   logic [COORD_W-1:0] row_cnt_q, row_cnt_d;
   logic               is_wall_q, is_wall_d;
   logic               game_is_wall_q, game_is_wall_d;

   logic [MAP_W-1:0]   map_rows [MAP_H];

   logic               drain_allowed;
   logic               init_we;
   logic               cell_we;
   logic               wr_ready;
   logic               fifo_push;
   logic               fifo_pop;
   logic               fifo_flush;
   logic               fifo_full;
   logic               fifo_empty;
   logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count;
   wr_entry_t          fifo_din;
   wr_entry_t          fifo_dout;

`ifdef WALL_MAP_FRAME_SYNC_EN
   assign drain_allowed = !bus.i_buzy;
`else
   logic unused_buzy;
   assign unused_buzy   = bus.i_buzy;
   assign drain_allowed = 1'b1;
`endif

   logic unused_fifo_count;
   assign unused_fifo_count = ^fifo_count;

   // Ready depends only on registered state, never on i_wr_valid.
   assign wr_ready  = !fifo_full && (state_q != ST_INIT);
   assign fifo_push = bus.i_wr_valid && wr_ready;
   assign fifo_din  = '{x: bus.i_wr_x, y: bus.i_wr_y, data: bus.i_wr_data};

   wall_wr_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_wr_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_flush (fifo_flush),
      .i_push  (fifo_push),
      .i_data  (fifo_din),
      .i_pop   (fifo_pop),
      .o_data  (fifo_dout),
      .o_full  (fifo_full),
      .o_empty (fifo_empty),
      .o_count (fifo_count)
   );

   // ---------------------------------------------------------------- control
   always_comb begin
      state_d    = state_q;
      row_cnt_d  = row_cnt_q;
      init_we    = 1'b0;
      fifo_pop   = 1'b0;
      fifo_flush = 1'b0;
      case (state_q)
         ST_INIT: begin
            init_we   = 1'b1;
            row_cnt_d = row_cnt_q + 1'b1;
            if (row_cnt_q == LAST_ROW) begin
               state_d   = ST_IDLE;
               row_cnt_d = '0;
            end
         end
         ST_IDLE: begin
            if (!fifo_empty && drain_allowed) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (fifo_empty || !drain_allowed) begin
               state_d = ST_IDLE;
            end else begin
               fifo_pop = 1'b1;
            end
         end
         default: begin
            state_d   = ST_INIT;
            row_cnt_d = '0;
         end
      endcase
      // A clear discards everything queued, including the entry that would
      // otherwise be applied this cycle, and restarts the rebuild.
      if (bus.i_clear) begin
         state_d    = ST_INIT;
         row_cnt_d  = '0;
         fifo_pop   = 1'b0;
         fifo_flush = 1'b1;
      end
   end

   // Off-field rows are accepted into the FIFO but dropped here.
   assign cell_we = fifo_pop && (fifo_dout.y <= LAST_ROW);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_INIT;
         row_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         row_cnt_q <= row_cnt_d;
      end
   end

   // ---------------------------------------------------------------- storage
   // One register row per field row; each row only loads itself, either the
   // whole default pattern during INIT or a single bit from the FIFO head.
   genvar gi;
   generate
      for (gi = 0; gi < MAP_H; gi++) begin : g_row
         localparam logic [COORD_W-1:0] ROW_IDX = COORD_W'(gi);
         logic [MAP_W-1:0] row_q;

         always_ff @(posedge clk) begin
            if (rst_n) begin
               if (init_we && (row_cnt_q == ROW_IDX)) begin
                  row_q <= default_row(ROW_IDX);
               end else if (cell_we && (fifo_dout.y == ROW_IDX)) begin
                  row_q[fifo_dout.x] <= fifo_dout.data;
               end
            end
         end

         assign map_rows[gi] = row_q;
      end
   endgenerate

   // ------------------------------------------------------------ read ports
   // Reads sample the map before this cycle's write lands, so a read of a
   // cell being written returns the old value.
   always_comb begin
      is_wall_d      = 1'b1;
      game_is_wall_d = 1'b1;
      if (bus.i_request_y <= LAST_ROW) begin
         is_wall_d = map_rows[bus.i_request_y][bus.i_request_x];
      end
      if (bus.i_game_y <= LAST_ROW) begin
         game_is_wall_d = map_rows[bus.i_game_y][bus.i_game_x];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         is_wall_q      <= 1'b0;
         game_is_wall_q <= 1'b0;
      end else begin
         is_wall_q      <= is_wall_d;
         game_is_wall_q <= game_is_wall_d;
      end
   end

   assign bus.o_is_wall      = is_wall_q;
   assign bus.o_game_is_wall = game_is_wall_q;
   assign bus.o_wr_ready     = wr_ready;
   assign bus.o_init_done    = (state_q != ST_INIT);

endmodule

// File: tb/tb_wall_map_server.sv
// -----------------------------------------------------------------------------
// tb_wall_map_server
// Directed sequence plus randomized writes against an array model of the
// 64x44 wall map built straight from the field rules (border + tile pillars).
// -----------------------------------------------------------------------------
module tb_wall_map_server;

   localparam int W = 64;
   localparam int H = 44;

   typedef struct {
      int x;
      int y;
      bit d;
   } wr_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   int n_cmp = 0;
   int n_mis = 0;

   bit  ref_map [H][W];
   wr_t pending [$];

   wall_map_server_if bus ();

   wall_map_server dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // ------------------------------------------------------------ model
   function automatic bit default_wall(input int x, input int y);
      return (x == 0) || (x == W - 1) || (y == 0) || (y == H - 1) ||
             (((x % 8) == 4) && ((y % 8) == 4));
   endfunction

   function automatic bit ref_cell(input int x, input int y);
      if (y >= H) return 1'b1;
      return ref_map[y][x];
   endfunction

   task automatic model_reset();
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++)
            ref_map[y][x] = default_wall(x, y);
      pending.delete();
   endtask

   // Queued writes land in order; off-field rows vanish.
   task automatic apply_pending();
      while (pending.size() > 0) begin
         wr_t e;
         e = pending.pop_front();
         if (e.y < H) ref_map[e.y][e.x] = e.d;
      end
   endtask

   // ------------------------------------------------------------ helpers
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_mis++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int x, input int y, input bit d);
      int n;
      n = 0;
      bus.i_wr_valid = 1'b1;
      bus.i_wr_x     = 6'(x);
      bus.i_wr_y     = 6'(y);
      bus.i_wr_data  = d;
      while (!bus.o_wr_ready && n < 50) begin
         tick();
         n++;
      end
      chk($sformatf("push_ready(%0d,%0d)", x, y), bus.o_wr_ready, 1);
      tick();
      bus.i_wr_valid = 1'b0;
      pending.push_back('{x: x, y: y, d: d});
   endtask

   task automatic wait_init(input string tag);
      int n;
      n = 0;
      while (!bus.o_init_done && n < 100) begin
         tick();
         n++;
      end
      chk(tag, n, 44);
   endtask

   task automatic sweep(input string tag);
      for (int y = 0; y < 64; y++) begin
         for (int x = 0; x < 64; x++) begin
            bus.i_request_x = 6'(x);
            bus.i_request_y = 6'(y);
            bus.i_game_x    = 6'(63 - x);
            bus.i_game_y    = 6'(63 - y);
            tick();
            chk($sformatf("%s_disp(%0d,%0d)", tag, x, y), bus.o_is_wall, ref_cell(x, y));
            chk($sformatf("%s_game(%0d,%0d)", tag, 63 - x, 63 - y),
                bus.o_game_is_wall, ref_cell(63 - x, 63 - y));
         end
      end
   endtask

   task automatic query(input string tag, input int x, input int y);
      bus.i_request_x = 6'(x);
      bus.i_request_y = 6'(y);
      bus.i_game_x    = 6'(x);
      bus.i_game_y    = 6'(y);
      tick();
      chk({tag, "_disp"}, bus.o_is_wall, ref_cell(x, y));
      chk({tag, "_game"}, bus.o_game_is_wall, ref_cell(x, y));
   endtask

   // Push one write and count cycles after acceptance until the collision
   // port first shows the new value: queue -> DRAIN -> write -> read.
   task automatic write_latency(input string tag, input int x, input int y, input bit d);
      int first;
      first = 0;
      bus.i_game_x = 6'(x);
      bus.i_game_y = 6'(y);
      push(x, y, d);
      for (int k = 1; k <= 6; k++) begin
         tick();
         if (first == 0 && bus.o_game_is_wall === d) first = k;
      end
      chk(tag, first, 3);
      apply_pending();
   endtask

   // ------------------------------------------------------------ sequence
   initial begin
      bus.i_request_x = '0;
      bus.i_request_y = '0;
      bus.i_buzy      = 1'b0;
      bus.i_game_x    = '0;
      bus.i_game_y    = '0;
      bus.i_wr_valid  = 1'b0;
      bus.i_wr_x      = '0;
      bus.i_wr_y      = '0;
      bus.i_wr_data   = 1'b0;
      bus.i_clear     = 1'b0;
      model_reset();

      // Reset values
      rst_n = 1'b0;
      repeat (3) tick();
      chk("rst_is_wall", bus.o_is_wall, 0);
      chk("rst_game_is_wall", bus.o_game_is_wall, 0);
      chk("rst_wr_ready", bus.o_wr_ready, 0);
      chk("rst_init_done", bus.o_init_done, 0);
      rst_n = 1'b1;
      wait_init("init_after_reset");
      chk("ready_after_init", bus.o_wr_ready, 1);

      // Directed default-map points, then the whole field plus off-field rows
      query("q_0_5", 0, 5);
      query("q_4_4", 4, 4);
      query("q_5_5", 5, 5);
      query("q_row50", 7, 50);
      sweep("default");

      // Single writes with exact landing time; read-old-on-write
      write_latency("land_5_5_1", 5, 5, 1'b1);
      write_latency("land_4_4_0", 4, 4, 1'b0);
      query("q_5_5_after", 5, 5);
      query("q_4_4_after", 4, 4);

`ifdef WALL_MAP_FRAME_SYNC_EN
      // Writes are held back through the active region until the FIFO fills
      bus.i_buzy = 1'b1;
      for (int i = 0; i < 4; i++) push(40 + i, 9, 1'b1);
      chk("ready_when_full", bus.o_wr_ready, 0);
      repeat (3) tick();
      for (int i = 0; i < 4; i++) query($sformatf("held_%0d", i), 40 + i, 9);
      bus.i_buzy = 1'b0;
      repeat (8) tick();
      chk("ready_after_drain", bus.o_wr_ready, 1);
      apply_pending();
      for (int i = 0; i < 4; i++) query($sformatf("landed_%0d", i), 40 + i, 9);
`else
      // i_buzy has no effect on draining
      bus.i_buzy = 1'b1;
      write_latency("land_buzy_10_10", 10, 10, 1'b1);
      bus.i_buzy = 1'b0;
`endif

      // Random single writes, including off-field rows
      for (int i = 0; i < 24; i++) begin
         int x, y, rx, ry;
         bit d;
         x  = $urandom_range(0, 63);
         y  = $urandom_range(0, 47);
         d  = 1'($urandom_range(0, 1));
         rx = $urandom_range(0, 63);
         ry = $urandom_range(0, 43);
         push(x, y, d);
         repeat (4) tick();
         apply_pending();
         bus.i_game_x    = 6'(x);
         bus.i_game_y    = 6'(y);
         bus.i_request_x = 6'(rx);
         bus.i_request_y = 6'(ry);
         tick();
         chk($sformatf("rnd_game(%0d,%0d)", x, y), bus.o_game_is_wall, ref_cell(x, y));
         chk($sformatf("rnd_disp(%0d,%0d)", rx, ry), bus.o_is_wall, ref_cell(rx, ry));
      end

      // Back-to-back random burst, then full compare
      for (int i = 0; i < 12; i++) begin
         push($urandom_range(0, 63), $urandom_range(0, 47), 1'($urandom_range(0, 1)));
      end
      repeat (8) tick();
      apply_pending();
      sweep("burst");

      // Clear with two entries queued: they must never reach the map
      push(30, 30, 1'b1);
      push(31, 31, 1'b1);
      bus.i_clear = 1'b1;
      tick();
      bus.i_clear = 1'b0;
      model_reset();
      chk("clear_init_done", bus.o_init_done, 0);
      chk("clear_wr_ready", bus.o_wr_ready, 0);
      // Clear again part-way through the rebuild: it restarts from row 0
      repeat (10) tick();
      bus.i_clear = 1'b1;
      tick();
      bus.i_clear = 1'b0;
      chk("reclear_init_done", bus.o_init_done, 0);
      wait_init("init_after_clear");
      repeat (6) tick();
      query("cleared_30_30", 30, 30);
      query("cleared_31_31", 31, 31);
      sweep("clear");

      // Reset while writes are draining
      push(12, 12, 1'b1);
      push(13, 13, 1'b1);
      push(14, 14, 1'b1);
      rst_n = 1'b0;
      tick();
      chk("mid_rst_is_wall", bus.o_is_wall, 0);
      chk("mid_rst_game_is_wall", bus.o_game_is_wall, 0);
      chk("mid_rst_wr_ready", bus.o_wr_ready, 0);
      chk("mid_rst_init_done", bus.o_init_done, 0);
      rst_n = 1'b1;
      model_reset();
      wait_init("init_after_mid_reset");
      sweep("reset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
